// File: rtl/m_ghost_collision_n.sv
// Player-vs-ghost collision checker: scans one ghost per cycle and detects same-tile and tile-swap hits.
// It also owns the lives counter, the post-hit grace window and the sticky game-over flag.
module m_ghost_collision_n #(
    parameter int NUM_GHOSTS  = 3,
    parameter int X_W         = 5,
    parameter int Y_W         = 4,
    parameter int LIVES_INIT  = 3,
    parameter int GRACE_TICKS = 8,
    parameter int CROSS_CHECK = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      tick,
    input  logic [X_W-1:0]            player_x,
    input  logic [Y_W-1:0]            player_y,
    input  logic [NUM_GHOSTS*X_W-1:0] ghost_x,
    input  logic [NUM_GHOSTS*Y_W-1:0] ghost_y,
    output logic                      finished,
    output logic                      ghost_collision,
    output logic [NUM_GHOSTS-1:0]     hit_mask,
    output logic [3:0]                hit_index,
    output logic [3:0]                lives,
    output logic                      grace_active,
    output logic                      game_over
);

    localparam int IDX_W = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
    localparam int G_W   = (GRACE_TICKS > 0) ? $clog2(GRACE_TICKS + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESOLVE, S_DONE} state_t;

    state_t                r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [NUM_GHOSTS-1:0] r_work;
    logic [G_W-1:0]        r_grace;
    logic                  r_prev_valid;

    logic [X_W-1:0] r_px, r_prev_px;
    logic [Y_W-1:0] r_py, r_prev_py;
    logic [X_W-1:0] r_gx      [NUM_GHOSTS];
    logic [Y_W-1:0] r_gy      [NUM_GHOSTS];
    logic [X_W-1:0] r_prev_gx [NUM_GHOSTS];
    logic [Y_W-1:0] r_prev_gy [NUM_GHOSTS];

    logic w_start, w_same, w_cross, w_hit, w_counted;

    function automatic logic [3:0] lowest_set(input logic [NUM_GHOSTS-1:0] mask);
        lowest_set = 4'd0;
        for (int i = NUM_GHOSTS - 1; i >= 0; i--)
            if (mask[i]) lowest_set = 4'(i);
    endfunction

    assign w_start   = enable && (r_state == S_IDLE || r_state == S_DONE);
    assign w_counted = (|r_work) && (r_grace == '0) && (lives != 4'd0);

    always_comb begin
        w_same  = (r_px == r_gx[r_idx]) && (r_py == r_gy[r_idx]);
        w_cross = (CROSS_CHECK != 0) && r_prev_valid
               && (r_px == r_prev_gx[r_idx]) && (r_py == r_prev_gy[r_idx])
               && (r_gx[r_idx] == r_prev_px) && (r_gy[r_idx] == r_prev_py);
        w_hit   = w_same || w_cross;
    end

    // NOTE: snapshot and history registers are deliberately left out of reset; they are
    // always written before being read, and r_prev_valid guards the history copy.
    always_ff @(posedge clock) begin
        if (w_start) begin
            r_px <= player_x;
            r_py <= player_y;
            for (int i = 0; i < NUM_GHOSTS; i++) begin
                r_gx[i] <= ghost_x[i*X_W +: X_W];
                r_gy[i] <= ghost_y[i*Y_W +: Y_W];
            end
        end
        if (r_state == S_RESOLVE) begin
            r_prev_px <= r_px;
            r_prev_py <= r_py;
            for (int i = 0; i < NUM_GHOSTS; i++) begin
                r_prev_gx[i] <= r_gx[i];
                r_prev_gy[i] <= r_gy[i];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_idx           <= '0;
            r_work          <= '0;
            r_prev_valid    <= 1'b0;
            finished        <= 1'b0;
            ghost_collision <= 1'b0;
            hit_mask        <= '0;
            hit_index       <= 4'd0;
            lives           <= 4'(LIVES_INIT);
            game_over       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (enable) begin
                        r_work   <= '0;
                        r_idx    <= '0;
                        finished <= 1'b0;
                        r_state  <= S_SCAN;
                    end else if (r_state == S_DONE) begin
                        finished <= 1'b1;
                    end
                end
                S_SCAN: begin
                    r_work[r_idx] <= w_hit;
                    if (r_idx == IDX_W'(NUM_GHOSTS - 1)) r_state <= S_RESOLVE;
                    else                                 r_idx   <= r_idx + 1'b1;
                end
                S_RESOLVE: begin
                    hit_mask        <= r_work;
                    ghost_collision <= |r_work;
                    hit_index       <= lowest_set(r_work);
                    r_prev_valid    <= 1'b1;
                    if (w_counted) begin
                        lives <= lives - 4'd1;
                        if (lives == 4'd1) game_over <= 1'b1;
                    end
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A counted hit reloads the window and wins over a coincident tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                                r_grace <= '0;
        else if (r_state == S_RESOLVE && w_counted) r_grace <= G_W'(GRACE_TICKS);
        else if (tick && r_grace != '0)           r_grace <= r_grace - 1'b1;
    end

    assign grace_active = (r_grace != '0);

endmodule

// File: tb/tb_m_ghost_collision_n.sv
// Directed bench for m_ghost_collision_n: a reference model pushes expected results to a
// scoreboard queue at each start, and they are popped and compared once finished rises.
module tb_m_ghost_collision_n;

    typedef struct {
        logic [2:0] mask;
        logic       coll;
        logic [3:0] idx;
        logic [3:0] lives;
        logic       grace;
        logic       go;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        tick = 1'b0;
    logic [4:0]  player_x = '0;
    logic [3:0]  player_y = '0;
    logic [14:0] gx3 = '0;
    logic [11:0] gy3 = '0;
    logic [39:0] gx8 = {8{5'd31}};
    logic [31:0] gy8 = {8{4'd15}};

    logic       fin, coll, gact, gover;
    logic [2:0] hmask;
    logic [3:0] hidx, lives;
    logic       nc_fin, nc_coll, nc_gact, nc_gover;
    logic [2:0] nc_hmask;
    logic [3:0] nc_hidx, nc_lives;
    logic       d8_fin, d8_coll, d8_gact, d8_gover;
    logic [7:0] d8_hmask;
    logic [3:0] d8_hidx, d8_lives;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t sb[$];

    logic [3:0] m_lives;
    logic [3:0] m_grace;
    logic       m_go, m_pv;
    logic [4:0] m_ppx;
    logic [3:0] m_ppy;
    logic [4:0] m_pgx [3];
    logic [3:0] m_pgy [3];

    m_ghost_collision_n dut (
        .clock(clock), .reset(reset), .enable(enable), .tick(tick),
        .player_x(player_x), .player_y(player_y), .ghost_x(gx3), .ghost_y(gy3),
        .finished(fin), .ghost_collision(coll), .hit_mask(hmask), .hit_index(hidx),
        .lives(lives), .grace_active(gact), .game_over(gover)
    );

    m_ghost_collision_n #(.CROSS_CHECK(0)) dut_nc (
        .clock(clock), .reset(reset), .enable(enable), .tick(tick),
        .player_x(player_x), .player_y(player_y), .ghost_x(gx3), .ghost_y(gy3),
        .finished(nc_fin), .ghost_collision(nc_coll), .hit_mask(nc_hmask), .hit_index(nc_hidx),
        .lives(nc_lives), .grace_active(nc_gact), .game_over(nc_gover)
    );

    m_ghost_collision_n #(.NUM_GHOSTS(8)) dut8 (
        .clock(clock), .reset(reset), .enable(enable), .tick(tick),
        .player_x(player_x), .player_y(player_y), .ghost_x(gx8), .ghost_y(gy8),
        .finished(d8_fin), .ghost_collision(d8_coll), .hit_mask(d8_hmask), .hit_index(d8_hidx),
        .lives(d8_lives), .grace_active(d8_gact), .game_over(d8_gover)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lives = 4'd3;
        m_grace = 4'd0;
        m_go    = 1'b0;
        m_pv    = 1'b0;
    endtask

    task automatic do_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clock) tick = 1'b1;
            @(negedge clock) tick = 1'b0;
            if (m_grace != 0) m_grace = m_grace - 1;
        end
    endtask

    function automatic logic [14:0] pk_x(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        return {c, b, a};
    endfunction

    function automatic logic [11:0] pk_y(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        return {c, b, a};
    endfunction

    // Model one full check, start it on the DUTs, wait for finished and compare.
    task automatic do_check(input string name, input logic [4:0] px, input logic [3:0] py,
                            input logic [14:0] gx, input logic [11:0] gy,
                            input bit tick_res, input bit spur_en, input bit chk_lat);
        exp_t e, got;
        int   cycles;
        logic counted;
        e.mask = '0;
        for (int i = 0; i < 3; i++) begin
            logic [4:0] x;
            logic [3:0] y;
            x = gx[i*5 +: 5];
            y = gy[i*4 +: 4];
            if ((px == x && py == y) ||
                (m_pv && px == m_pgx[i] && py == m_pgy[i] && x == m_ppx && y == m_ppy))
                e.mask[i] = 1'b1;
        end
        e.coll = |e.mask;
        e.idx  = e.mask[0] ? 4'd0 : e.mask[1] ? 4'd1 : e.mask[2] ? 4'd2 : 4'd0;
        counted = e.coll && m_grace == 0 && m_lives != 0;
        if (counted) begin
            m_lives = m_lives - 1;
            m_grace = 4'd8;
            if (m_lives == 0) m_go = 1'b1;
        end else if (tick_res && m_grace != 0) begin
            m_grace = m_grace - 1;
        end
        m_pv  = 1'b1;
        m_ppx = px;
        m_ppy = py;
        for (int i = 0; i < 3; i++) begin
            m_pgx[i] = gx[i*5 +: 5];
            m_pgy[i] = gy[i*4 +: 4];
        end
        e.lives = m_lives;
        e.grace = (m_grace != 0);
        e.go    = m_go;
        sb.push_back(e);

        @(negedge clock);
        player_x = px;
        player_y = py;
        gx3      = gx;
        gy3      = gy;
        enable   = 1'b1;
        @(negedge clock);
        enable = 1'b0;
        cycles = 0;
        if (chk_lat) check({name, "_fin_low"}, 32'(fin), 32'd0);
        while (!fin && cycles < 20) begin
            @(negedge clock);
            cycles++;
            tick   = tick_res && (cycles == 3);
            enable = spur_en && (cycles == 2);
        end
        tick   = 1'b0;
        enable = 1'b0;
        check({name, "_finished"}, 32'(fin), 32'd1);
        if (chk_lat) check({name, "_latency"}, 32'(cycles), 32'd5);

        got = sb.pop_front();
        check({name, "_mask"},  32'(hmask), 32'(got.mask));
        check({name, "_coll"},  32'(coll),  32'(got.coll));
        check({name, "_idx"},   32'(hidx),  32'(got.idx));
        check({name, "_lives"}, 32'(lives), 32'(got.lives));
        check({name, "_grace"}, 32'(gact),  32'(got.grace));
        check({name, "_gover"}, 32'(gover), 32'(got.go));
    endtask

    initial begin
        logic [14:0] gx_def, gx_cr1, gx_cr2, gx_h;
        logic [11:0] gy_def, gy_cr1, gy_cr2, gy_h;
        int          waitc;
        gx_def = pk_x(5'd5, 5'd7, 5'd9);   gy_def = pk_y(4'd2, 4'd3, 4'd4);
        gx_cr1 = pk_x(5'd5, 5'd20, 5'd21); gy_cr1 = pk_y(4'd4, 4'd10, 4'd11);
        gx_cr2 = pk_x(5'd4, 5'd20, 5'd21); gy_cr2 = pk_y(4'd4, 4'd10, 4'd11);
        gx_h   = pk_x(5'd1, 5'd2, 5'd3);   gy_h   = pk_y(4'd1, 4'd2, 4'd3);

        model_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_finished", 32'(fin),   32'd0);
        check("rst_coll",     32'(coll),  32'd0);
        check("rst_mask",     32'(hmask), 32'd0);
        check("rst_idx",      32'(hidx),  32'd0);
        check("rst_lives",    32'(lives), 32'd3);
        check("rst_grace",    32'(gact),  32'd0);
        check("rst_gover",    32'(gover), 32'd0);
        reset = 1'b0;

        do_check("nohit", 5'd1, 4'd1, gx_def, gy_def, 0, 0, 1);
        check("nohit_mask_const", 32'(hmask), 32'd0);

        do_check("hit1", 5'd7, 4'd3, gx_def, gy_def, 0, 0, 1);
        check("hit1_mask_const", 32'(hmask), 32'b010);
        check("hit1_lives_const", 32'(lives), 32'd2);

        do_ticks(7);
        check("grace_after7", 32'(gact), 32'd1);
        do_check("hit_in_grace", 5'd7, 4'd3, gx_def, gy_def, 0, 0, 0);
        check("hit_in_grace_lives", 32'(lives), 32'd2);
        do_ticks(1);
        check("grace_after8", 32'(gact), 32'd0);

        do_check("hit2", 5'd7, 4'd3, gx_def, gy_def, 0, 0, 0);
        check("hit2_lives_const", 32'(lives), 32'd1);
        do_ticks(8);

        do_check("cross_a", 5'd4, 4'd4, gx_cr1, gy_cr1, 0, 0, 0);
        do_check("cross_b", 5'd5, 4'd4, gx_cr2, gy_cr2, 1, 0, 0);
        check("cross_b_mask0", 32'(hmask[0]), 32'd1);
        check("nocross_mask0", 32'(nc_hmask[0]), 32'd0);
        check("nocross_coll", 32'(nc_coll), 32'd0);
        check("gameover_lives", 32'(lives), 32'd0);
        check("gameover_flag", 32'(gover), 32'd1);

        do_ticks(7);
        check("tick_at_resolve_7", 32'(gact), 32'(m_grace != 0));
        check("tick_at_resolve_7_const", 32'(gact), 32'd1);
        do_ticks(1);
        check("tick_at_resolve_8", 32'(gact), 32'd0);

        do_check("after_gameover", 5'd7, 4'd3, gx_def, gy_def, 0, 1, 1);
        check("after_gameover_lives", 32'(lives), 32'd0);
        check("after_gameover_coll", 32'(coll), 32'd1);

        repeat (12) @(negedge clock);
        gx8[2*5 +: 5] = 5'd10; gy8[2*4 +: 4] = 4'd6;
        gx8[5*5 +: 5] = 5'd10; gy8[5*4 +: 4] = 4'd6;
        do_check("wide_main", 5'd10, 4'd6, gx_h, gy_h, 0, 0, 0);
        waitc = 0;
        while (!d8_fin && waitc < 20) begin
            @(negedge clock);
            waitc++;
        end
        check("wide_finished", 32'(d8_fin),   32'd1);
        check("wide_mask",     32'(d8_hmask), 32'h24);
        check("wide_idx",      32'(d8_hidx),  32'd2);
        check("wide_lives",    32'(d8_lives), 32'd2);

        @(negedge clock) enable = 1'b1;
        @(negedge clock) enable = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("midscan_finished", 32'(fin),   32'd0);
        check("midscan_coll",     32'(coll),  32'd0);
        check("midscan_mask",     32'(hmask), 32'd0);
        check("midscan_lives",    32'(lives), 32'd3);
        check("midscan_grace",    32'(gact),  32'd0);
        check("midscan_gover",    32'(gover), 32'd0);
        @(negedge clock) reset = 1'b0;
        model_reset();

        do_check("post_reset", 5'd1, 4'd1, gx_def, gy_def, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
